creek_host_ctrl: RTL and testbench

Host-side control peripheral for the Creek vector core. It is an Avalon-MM slave on the Nios system bus and is the host end of the core's pause/resume/waiting handshake. It also acts as the instruction-memory loader, writing the core's instruction RAM through an auto-incrementing pointer. Software uses it to halt the core, download a program, resume execution and observe completion.

---
 rtl/creek_host_ctrl.sv | 160 ++++++++++++++++
 tb/tb_creek_host_ctrl.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/creek_host_ctrl.sv
// Host-side control slave for the Creek vector core: pause/resume handshake,
// instruction RAM loader with auto-incrementing pointer, and a saturating
// count of the core's waiting rising edges. All outputs are registered.
module creek_host_ctrl #(
  parameter int INSTR_ADDR_WIDTH = 10,
  parameter int INSTR_DATA_WIDTH = 16
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic [1:0]                  avs_address,
  input  logic                        avs_read,
  input  logic                        avs_write,
  input  logic [31:0]                 avs_writedata,
  output logic [31:0]                 avs_readdata,
  output logic [INSTR_ADDR_WIDTH-1:0] instr_address,
  output logic [INSTR_DATA_WIDTH-1:0] instr_writedata,
  output logic                        instr_write,
  output logic                        pause_n,
  output logic                        resume,
  input  logic                        waiting
);

  localparam logic [1:0] REG_CTRL      = 2'd0;
  localparam logic [1:0] REG_LOAD_ADDR = 2'd1;
  localparam logic [1:0] REG_LOAD_DATA = 2'd2;
  localparam logic [1:0] REG_WAIT_CNT  = 2'd3;

  localparam logic [INSTR_ADDR_WIDTH-1:0] PTR_ONE = INSTR_ADDR_WIDTH'(1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ARM  = 2'd1,
    S_ACK  = 2'd2
  } rsm_t;

  rsm_t                        state, state_nxt;
  logic                        resume_nxt;
  logic [INSTR_ADDR_WIDTH-1:0] ptr;
  logic [15:0]                 wait_cnt;
  logic                        err;
  logic                        waiting_p1;
  logic                        wait_rise;
  logic                        ctrl_wr, addr_wr, data_wr, cnt_wr;
  logic                        pause_wr, resume_req, err_clr;
  logic [31:0]                 rd_mux;
  logic                        unused_wd;

  // Saturating increment: the counter sticks at all-ones instead of wrapping.
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  assign ctrl_wr    = avs_write && (avs_address == REG_CTRL);
  assign addr_wr    = avs_write && (avs_address == REG_LOAD_ADDR);
  assign data_wr    = avs_write && (avs_address == REG_LOAD_DATA);
  assign cnt_wr     = avs_write && (avs_address == REG_WAIT_CNT);
  // Pause wins over a resume request carried in the same write.
  assign pause_wr   = ctrl_wr && avs_writedata[0];
  assign resume_req = ctrl_wr && avs_writedata[1] && !avs_writedata[0];
  assign err_clr    = ctrl_wr && avs_writedata[2];
  assign wait_rise  = waiting && !waiting_p1;
  assign unused_wd  = ^avs_writedata[31:INSTR_DATA_WIDTH];

  // Resume FSM state register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_nxt;
  end

  // Resume FSM next state and pulse request; a pause write overrides everything.
  always_comb begin
    state_nxt  = state;
    resume_nxt = 1'b0;
    case (state)
      S_IDLE: if (resume_req) state_nxt = S_ARM;
      S_ARM: begin
        if (waiting) begin
          resume_nxt = 1'b1;
          state_nxt  = S_ACK;
        end
      end
      S_ACK:  if (!waiting) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
    if (pause_wr) begin
      state_nxt  = S_IDLE;
      resume_nxt = 1'b0;
    end
  end

  // Registered resume pulse and pause control (pause_n low holds the core).
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      resume  <= 1'b0;
      pause_n <= 1'b0;
    end else begin
      resume <= resume_nxt;
      if (ctrl_wr) pause_n <= ~avs_writedata[0];
    end
  end

  // Instruction loader: pointer update and one-cycle RAM write strobe.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ptr             <= '0;
      instr_write     <= 1'b0;
      instr_address   <= '0;
      instr_writedata <= '0;
    end else begin
      instr_write <= 1'b0;
      if (addr_wr) begin
        ptr <= avs_writedata[INSTR_ADDR_WIDTH-1:0];
      end else if (data_wr && !pause_n) begin
        instr_write     <= 1'b1;
        instr_address   <= ptr;
        instr_writedata <= avs_writedata[INSTR_DATA_WIDTH-1:0];
        ptr             <= ptr + PTR_ONE;
      end
    end
  end

  // Sticky error: set by a load attempted while the core runs, cleared by CTRL bit2.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                err <= 1'b0;
    else if (data_wr && pause_n) err <= 1'b1;
    else if (err_clr)            err <= 1'b0;
  end

  // Waiting edge detector and saturating edge counter; a write clears it.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      waiting_p1 <= 1'b0;
      wait_cnt   <= '0;
    end else begin
      waiting_p1 <= waiting;
      if (cnt_wr)         wait_cnt <= '0;
      else if (wait_rise) wait_cnt <= sat_inc16(wait_cnt);
    end
  end

  // Read data select; reads have no side effects.
  always_comb begin
    rd_mux = '0;
    case (avs_address)
      REG_CTRL:      rd_mux = {28'd0, err, (state != S_IDLE), waiting, ~pause_n};
      REG_LOAD_ADDR: rd_mux = {{(32-INSTR_ADDR_WIDTH){1'b0}}, ptr};
      REG_LOAD_DATA: rd_mux = '0;
      REG_WAIT_CNT:  rd_mux = {16'd0, wait_cnt};
      default:       rd_mux = '0;
    endcase
  end

  // Read data register, fixed latency of one cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)      avs_readdata <= '0;
    else if (avs_read) avs_readdata <= rd_mux;
    else               avs_readdata <= '0;
  end

endmodule

// File: tb/tb_creek_host_ctrl.sv
// Scoreboard bench for creek_host_ctrl: stimulus pushes expected read data and
// expected instruction writes into queues; a negedge monitor pops and compares.
module tb_creek_host_ctrl;

  logic        clk;
  logic        reset_n;
  logic [1:0]  avs_address;
  logic        avs_read;
  logic        avs_write;
  logic [31:0] avs_writedata;
  logic [31:0] avs_readdata;
  logic [9:0]  instr_address;
  logic [15:0] instr_writedata;
  logic        instr_write;
  logic        pause_n;
  logic        resume;
  logic        waiting;

  int vectors = 0;
  int miscompares = 0;
  int resume_cnt = 0;
  logic rd_p1 = 1'b0;

  logic [31:0] exp_rd[$];
  string       exp_rd_nm[$];
  logic [9:0]  exp_ia[$];
  logic [15:0] exp_id[$];

  creek_host_ctrl #(.INSTR_ADDR_WIDTH(10), .INSTR_DATA_WIDTH(16)) dut (
    .clk(clk), .reset_n(reset_n),
    .avs_address(avs_address), .avs_read(avs_read), .avs_write(avs_write),
    .avs_writedata(avs_writedata), .avs_readdata(avs_readdata),
    .instr_address(instr_address), .instr_writedata(instr_writedata),
    .instr_write(instr_write), .pause_n(pause_n), .resume(resume),
    .waiting(waiting)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s act=0x%0h exp=0x%0h @%0t", nm, act, exp, $time);
    end
  endtask

  always @(posedge clk) rd_p1 <= avs_read;

  // Monitor: compare read data and instruction writes whenever presented.
  always @(negedge clk) begin
    if (resume) resume_cnt++;
    if (rd_p1) begin
      if (exp_rd.size() == 0) begin
        vectors++; miscompares++;
        $display("FAIL rd_unexpected act=0x%0h exp=none", avs_readdata);
      end else begin
        check(exp_rd_nm.pop_front(), avs_readdata, exp_rd.pop_front());
      end
    end
    if (instr_write) begin
      if (exp_ia.size() == 0) begin
        vectors++; miscompares++;
        $display("FAIL instr_unexpected act=0x%0h exp=none", instr_address);
      end else begin
        check("instr_addr", {22'd0, instr_address}, {22'd0, exp_ia.pop_front()});
        check("instr_data", {16'd0, instr_writedata}, {16'd0, exp_id.pop_front()});
      end
    end
  end

  // All bus tasks start and end just after a rising edge and take one cycle.
  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    avs_write = 1'b1; avs_address = a; avs_writedata = d;
    @(posedge clk); #1;
    avs_write = 1'b0; avs_writedata = '0;
  endtask

  task automatic rd(input logic [1:0] a, input logic [31:0] e, input string nm);
    exp_rd.push_back(e); exp_rd_nm.push_back(nm);
    avs_read = 1'b1; avs_address = a;
    @(posedge clk); #1;
    avs_read = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic expect_load(input logic [9:0] a, input logic [15:0] d);
    exp_ia.push_back(a); exp_id.push_back(d);
  endtask

  task automatic toggle_waiting(input int n);
    for (int i = 0; i < n; i++) begin
      waiting = 1'b1; idle(1);
      waiting = 1'b0; idle(1);
    end
  endtask

  initial begin
    reset_n = 1'b1; avs_address = '0; avs_read = 1'b0; avs_write = 1'b0;
    avs_writedata = '0; waiting = 1'b0;
    #3 reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    // Reset values
    check("rst_pause_n", {31'd0, pause_n}, 32'd0);
    check("rst_resume", {31'd0, resume}, 32'd0);
    check("rst_instr_write", {31'd0, instr_write}, 32'd0);
    check("rst_instr_addr", {22'd0, instr_address}, 32'd0);
    check("rst_instr_data", {16'd0, instr_writedata}, 32'd0);
    check("rst_readdata", avs_readdata, 32'd0);
    reset_n = 1'b1;
    idle(1);
    rd(2'd0, 32'h1, "rst_status");
    rd(2'd1, 32'h0, "rst_ptr");
    rd(2'd2, 32'h0, "rst_load_data");
    rd(2'd3, 32'h0, "rst_wait_cnt");

    // Load with pointer wrap
    wr(2'd1, 32'h3FE);
    expect_load(10'h3FE, 16'h1111);
    expect_load(10'h3FF, 16'h2222);
    expect_load(10'h000, 16'h3333);
    wr(2'd2, 32'hFFFF_1111);
    wr(2'd2, 32'h1111_2222);
    wr(2'd2, 32'h0000_3333);
    rd(2'd1, 32'h001, "ptr_after_wrap");
    rd(2'd0, 32'h1, "status_after_load");

    // Load while running is dropped and flags error
    wr(2'd0, 32'h0);
    check("pause_n_running", {31'd0, pause_n}, 32'd1);
    wr(2'd2, 32'hBEEF);
    idle(1);
    rd(2'd1, 32'h001, "ptr_unchanged");
    rd(2'd0, 32'h8, "status_err");
    wr(2'd0, 32'h4);
    rd(2'd0, 32'h0, "status_err_clr");

    // Resume handshake
    wr(2'd0, 32'h2);
    rd(2'd0, 32'h4, "status_pending");
    idle(3);
    check("no_resume_yet", resume_cnt, 0);
    waiting = 1'b1;
    idle(4);
    check("one_resume", resume_cnt, 1);
    rd(2'd0, 32'h6, "status_ack");
    waiting = 1'b0;
    idle(2);
    rd(2'd0, 32'h0, "status_idle");

    // Pause override while armed, in the cycle waiting rises
    wr(2'd0, 32'h2);
    rd(2'd0, 32'h4, "status_armed");
    waiting = 1'b1;
    wr(2'd0, 32'h3);
    check("override_pause_n", {31'd0, pause_n}, 32'd0);
    rd(2'd0, 32'h3, "status_override");
    idle(3);
    check("override_no_pulse", resume_cnt, 1);
    waiting = 1'b0;
    idle(1);

    // Request with waiting already high: pulse exactly at N+2
    waiting = 1'b1;
    idle(1);
    wr(2'd0, 32'h2);
    @(negedge clk); check("resume_n1", {31'd0, resume}, 32'd0);
    @(negedge clk); check("resume_n2", {31'd0, resume}, 32'd1);
    @(negedge clk); check("resume_n3", {31'd0, resume}, 32'd0);
    @(posedge clk); #1;
    waiting = 1'b0;
    idle(2);
    rd(2'd0, 32'h0, "status_after_n2");
    check("two_resumes", resume_cnt, 2);

    // WAIT_COUNT edges, read/edge and clear/edge collisions
    wr(2'd3, 32'h0);
    toggle_waiting(5);
    rd(2'd3, 32'd5, "wait_cnt_5");
    waiting = 1'b1;
    rd(2'd3, 32'd5, "wait_cnt_pre_inc");
    waiting = 1'b0;
    idle(1);
    rd(2'd3, 32'd6, "wait_cnt_6");
    waiting = 1'b1;
    wr(2'd3, 32'h0);
    waiting = 1'b0;
    idle(1);
    rd(2'd3, 32'd0, "wait_cnt_clr_edge");

    // Saturation
    force dut.wait_cnt = 16'hFFFE;
    @(posedge clk); #1;
    release dut.wait_cnt;
    toggle_waiting(3);
    rd(2'd3, 32'hFFFF, "wait_cnt_sat");
    wr(2'd3, 32'h1234);
    rd(2'd3, 32'h0, "wait_cnt_wr_clr");

    // Reset in the middle of activity
    wr(2'd0, 32'h0);
    wr(2'd2, 32'hAAAA);
    wr(2'd1, 32'h55);
    toggle_waiting(1);
    wr(2'd0, 32'h2);
    reset_n = 1'b0;
    #1;
    check("midrst_pause_n", {31'd0, pause_n}, 32'd0);
    check("midrst_resume", {31'd0, resume}, 32'd0);
    idle(2);
    reset_n = 1'b1;
    idle(1);
    rd(2'd0, 32'h1, "midrst_status");
    rd(2'd1, 32'h0, "midrst_ptr");
    rd(2'd3, 32'h0, "midrst_wait_cnt");

    idle(3);
    check("rd_queue_empty", exp_rd.size(), 0);
    check("instr_queue_empty", exp_ia.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
